// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator-pair PUF measurement engine:
// controller state encoding, synchroniser flush length and a width helper.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        CMP
    } state_t;

    // Cycles spent after a mux change before edges are trusted again
    // (two synchroniser flops plus the edge-detect register).
    localparam int ARM_CYC = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/puf_edge_cnt.sv
// One measurement channel: two-flop synchroniser for an asynchronous RO
// output, 0->1 edge detector, and a saturating edge counter with a
// synchronous clear and a count enable.
module puf_edge_cnt
    import puf_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise;
    logic             cnt_full;

    assign rise     = sync2_q & ~prev_q;
    assign cnt_full = &cnt_q;
    assign cnt_o    = cnt_q;

    // Synchronise, remember the previous sample, and count rising edges
    // without wrapping once the counter is all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i && rise && !cnt_full) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_ro_arbiter.sv
// Ring-oscillator-pair PUF measurement engine. The challenge picks one RO
// pair; rising edges of both oscillators are counted over a WIN_CYC window
// and compared to give a 1-bit response with a single-cycle finished pulse.
// Optional build macro PUF_MAJORITY_EN: repeat the measurement NVOTE times
// on the latched challenge and report the majority of the per-round results.
module puf_ro_arbiter
    import puf_pkg::*;
#(
    parameter int CHAL_W  = 3,
    parameter int WIN_CYC = 64,
    parameter int CNT_W   = 8,
    parameter int NVOTE   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CHAL_W-1:0]          challenge,
    input  logic [2**(CHAL_W+1)-1:0]   ro_in,
    output logic                       busy,
    output logic                       response,
    output logic                       finished
);

    localparam int               WIN_W    = clog2(WIN_CYC + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [1:0]       ARM_LAST = 2'(ARM_CYC - 1);

    state_t             state_q;
    logic [CHAL_W-1:0]  chal_q;
    logic [1:0]         arm_q;
    logic [WIN_W-1:0]   win_q;
    logic               busy_q;
    logic               resp_q;
    logic               fin_q;

    logic [CHAL_W:0]    sel_a;
    logic [CHAL_W:0]    sel_b;
    logic               cnt_clr;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;
    logic               a_gt_b_d;

`ifdef PUF_MAJORITY_EN
    localparam int                VOTE_W    = clog2(NVOTE + 1);
    localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(NVOTE - 1);
    localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(NVOTE / 2);

    logic [VOTE_W-1:0]  round_q;
    logic [VOTE_W-1:0]  votes_q;
    logic [VOTE_W-1:0]  votes_d;

    assign votes_d = votes_q + VOTE_W'(a_gt_b_d);
`endif

    // Only the selected pair reaches the synchronisers.
    assign sel_a    = {chal_q, 1'b0};
    assign sel_b    = {chal_q, 1'b1};
    assign cnt_clr  = (state_q == ARM);
    assign cnt_en   = (state_q == COUNT);
    assign a_gt_b_d = (cnt_a > cnt_b);

    puf_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro_i  (ro_in[sel_a]),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt_a)
    );

    puf_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro_i  (ro_in[sel_b]),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt_b)
    );

    // Measurement controller: IDLE -> ARM (flush) -> COUNT (window) -> CMP.
    // busy stays high through the finished cycle, so IDLE drops it first
    // and only accepts a new start once busy is already low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chal_q  <= '0;
            arm_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            resp_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef PUF_MAJORITY_EN
            round_q <= '0;
            votes_q <= '0;
`endif
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (start) begin
                        chal_q  <= challenge;
                        busy_q  <= 1'b1;
                        arm_q   <= '0;
                        state_q <= ARM;
`ifdef PUF_MAJORITY_EN
                        round_q <= '0;
                        votes_q <= '0;
`endif
                    end
                end
                ARM: begin
                    arm_q <= arm_q + 1'b1;
                    if (arm_q == ARM_LAST) begin
                        win_q   <= '0;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    win_q <= win_q + 1'b1;
                    if (win_q == WIN_LAST) begin
                        state_q <= CMP;
                    end
                end
                CMP: begin
`ifdef PUF_MAJORITY_EN
                    if (round_q == VOTE_LAST) begin
                        resp_q  <= (votes_d > VOTE_HALF);
                        fin_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        votes_q <= votes_d;
                        round_q <= round_q + 1'b1;
                        arm_q   <= '0;
                        state_q <= ARM;
                    end
`else
                    resp_q  <= a_gt_b_d;
                    fin_q   <= 1'b1;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign response = resp_q;
    assign finished = fin_q;

endmodule

// File: tb/tb_puf_ro_arbiter.sv
// Self-checking bench for puf_ro_arbiter. RO inputs are generated from
// per-bit periods on the clk grid; every sampled ro_in value is logged and
// the reference result is computed by counting 0->1 transitions of the
// selected pair over the measurement window in that log.
module tb_puf_ro_arbiter;

    localparam int W      = 64;
    localparam int NHIST  = 16384;
`ifdef PUF_MAJORITY_EN
    localparam int NV = 3;
`else
    localparam int NV = 1;
`endif
    localparam int LAT = NV * (W + 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  challenge;
    logic [15:0] ro_in;
    logic        busy, response, finished;
    logic        busy2, response2, finished2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] hist [NHIST];
    int per [16];
    int ph  [16];
    bit lvl [16];

    typedef struct {
        int chal;
        int pa;
        int pb;
        bit iso;
        bit exp1;
        bit exp2;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    puf_ro_arbiter #(.CHAL_W(3), .WIN_CYC(W), .CNT_W(8), .NVOTE(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .busy(busy), .response(response), .finished(finished)
    );

    puf_ro_arbiter #(.CHAL_W(3), .WIN_CYC(W), .CNT_W(4), .NVOTE(3)) u_sat (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .busy(busy2), .response(response2), .finished(finished2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic v;
        @(posedge clk);
        hist[cyc % NHIST] = ro_in;
        cyc++;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (per[i] == 0) v = lvl[i];
            else             v = (((cyc + ph[i]) % per[i]) < (per[i] / 2));
            ro_in[i] = v;
        end
    endtask

    task automatic ro_quiet();
        for (int i = 0; i < 16; i++) begin
            per[i] = 0; ph[i] = 0; lvl[i] = 1'b0;
        end
    endtask

    // Rising transitions between consecutive samples 1..W+1 after the
    // round's first edge, clipped at the counter maximum.
    function automatic int rises(input int base, input int bitn, input int maxc);
        int n;
        n = 0;
        for (int j = 1; j <= W; j++) begin
            if (!hist[(base + j) % NHIST][bitn] && hist[(base + j + 1) % NHIST][bitn]) n++;
        end
        return (n > maxc) ? maxc : n;
    endfunction

    function automatic int model(input int e0, input int chal, input int maxc);
        int votes, a, b;
        votes = 0;
        for (int r = 0; r < NV; r++) begin
            a = rises(e0 + r * (W + 4), 2 * chal, maxc);
            b = rises(e0 + r * (W + 4), 2 * chal + 1, maxc);
            if (a > b) votes++;
        end
        return (votes > NV / 2) ? 1 : 0;
    endfunction

    // One full measurement; optional start/challenge noise while busy and
    // optional A/B period swaps at round boundaries.
    task automatic do_meas(input string name, input int chal, input bit inj,
                           input bit swap, output int e0);
        int fin_k, pulses, busy_fin, busy_after, t;
        fin_k = -1; pulses = 0; busy_fin = 0; busy_after = 1;
        challenge = 3'(chal);
        start = 1'b1;
        tick();
        e0 = cyc - 1;
        start = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (inj && (k == 10 || k == 40)) begin
                start = 1'b1; challenge = 3'(~chal);
            end else begin
                start = 1'b0; challenge = 3'(chal);
            end
            if (swap && (k == W + 4 || k == 2 * (W + 4))) begin
                t = per[2 * chal]; per[2 * chal] = per[2 * chal + 1]; per[2 * chal + 1] = t;
            end
            tick();
            if (finished) begin
                pulses++;
                if (fin_k < 0) begin fin_k = k; busy_fin = busy; end
            end
            if (k == LAT + 1) busy_after = busy;
        end
        start = 1'b0;
        chk({name, "_latency"}, fin_k, LAT);
        chk({name, "_pulses"}, pulses, 1);
        chk({name, "_busy_fin"}, busy_fin, 1);
        chk({name, "_busy_after"}, busy_after, 0);
        chk({name, "_resp"}, response, model(e0, chal, 255));
        chk({name, "_resp_sat"}, response2, model(e0, chal, 15));
    endtask

    initial begin
        int e0, e1, fk, pulses, busy_seen;

        vt[0] = '{2, 4, 8, 1'b0, 1'b1, 1'b1};
        vt[1] = '{2, 8, 4, 1'b0, 1'b0, 1'b0};
        vt[2] = '{2, 4, 4, 1'b0, 1'b0, 1'b0};
        vt[3] = '{3, 16, 16, 1'b0, 1'b0, 1'b0};
        vt[4] = '{5, 0, 0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{7, 6, 0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{0, 0, 4, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1, 4, 5, 1'b0, 1'b1, 1'b1};

        ro_quiet();
        ro_in = '0; rst = 1'b1; start = 1'b0; challenge = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_resp", response, 0);
        chk("rst_fin", finished, 0);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_resp", response, 0);
            chk("idle_fin", finished, 0);
        end

        for (int v = 0; v < 8; v++) begin
            ro_quiet();
            if (vt[v].iso) begin
                for (int p = 0; p < 8; p++) begin
                    if (p != vt[v].chal) begin per[2 * p] = 4; per[2 * p + 1] = 8; end
                end
            end
            per[2 * vt[v].chal]     = vt[v].pa;
            per[2 * vt[v].chal + 1] = vt[v].pb;
            repeat (2) tick();
            do_meas($sformatf("vec%0d", v), vt[v].chal, 1'b0, 1'b0, e0);
            chk($sformatf("vec%0d_tab", v), response, vt[v].exp1);
            chk($sformatf("vec%0d_tab_sat", v), response2, vt[v].exp2);
            tick();
        end

        // Starts and challenge changes while busy must be ignored.
        ro_quiet(); per[4] = 4; per[5] = 8;
        tick();
        do_meas("busy_start", 2, 1'b1, 1'b0, e0);
        chk("busy_start_tab", response, 1);

        // Start on the finished cycle is ignored, the next one is accepted.
        ro_quiet(); per[12] = 4; per[13] = 8;
        tick();
        challenge = 3'd6; start = 1'b1;
        tick();
        e0 = cyc - 1;
        start = 1'b0;
        for (int k = 1; k <= LAT; k++) tick();
        chk("fincyc_fin", finished, 1);
        start = 1'b1;
        tick();
        chk("fincyc_ignored_busy", busy, 0);
        chk("fincyc_ignored_fin", finished, 0);
        tick();
        e1 = cyc - 1;
        start = 1'b0;
        chk("next_start_busy", busy, 1);
        fk = -1;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (finished && fk < 0) fk = k;
        end
        chk("next_start_latency", fk, LAT);
        chk("next_start_resp", response, model(e1, 6, 255));

        // Reset in the middle of the counting window.
        ro_quiet(); per[4] = 4; per[5] = 8;
        challenge = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_fin", finished, 0);
        chk("midrst_resp", response, 0);
        rst = 1'b0;
        pulses = 0; busy_seen = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (finished) pulses++;
            if (busy) busy_seen++;
        end
        chk("midrst_no_fin", pulses, 0);
        chk("midrst_no_busy", busy_seen, 0);

        // Randomised pairs, phases and challenges.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 16; i++) begin
                per[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(4, 24));
                ph[i]  = int'($urandom_range(0, 23));
                lvl[i] = 1'($urandom_range(0, 1));
            end
            tick();
            do_meas($sformatf("rnd%0d", it), int'($urandom_range(0, 7)), 1'b0, 1'b0, e0);
        end

`ifdef PUF_MAJORITY_EN
        // Rounds A>B, A<B, A>B via swapped periods between rounds.
        ro_quiet(); per[2] = 4; per[3] = 8;
        tick();
        do_meas("vote", 1, 1'b0, 1'b1, e0);
        chk("vote_tab", response, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_ro_arbiter.md
Name: puf_ro_arbiter

Overview:
- Parametrised successor to the top-level PUF block (clk, rst, challenge, response, finished), which has no measurement logic and ties both outputs to 0.
- Implements a ring-oscillator-pair PUF measurement engine.
- The challenge selects one RO pair out of 2**CHAL_W pairs. Rising edges of both oscillators are counted over a fixed clk window, and the counts are compared to produce a 1-bit response with a `finished` pulse.
- RO macros are instantiated outside this block. Their divided outputs arrive on ro_in.

Parameters:
- CHAL_W, 3, challenge width; number of RO pairs = 2**CHAL_W; ro_in width = 2**(CHAL_W+1).
- WIN_CYC, 64, measurement window length in clk cycles (>=1).
- CNT_W, 8, edge-counter width; counters saturate at 2**CNT_W-1.
- NVOTE, 3, odd number of repeated measurements (used only with PUF_MAJORITY_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a measurement; sampled only in IDLE.
- challenge  input  CHAL_W  pair index; latched on accepted start.
- ro_in  input  2**(CHAL_W+1)  asynchronous divided RO outputs; pair i = ro_in[2i] (A), ro_in[2i+1] (B).
- busy  output  1  high from accepted start until the finished cycle (inclusive).
- response  output  1  1 when count_A > count_B; held until the next accepted start.
- finished  output  1  single-cycle pulse when response becomes valid.

Behaviour:
- Reset state:
  - Any rst assertion, including mid-measurement, forces IDLE.
  - Clears counters, synchronisers, and the latched challenge.
  - response=0, finished=0, busy=0.
- Input synchronisation and edge detection:
  - Only the selected pair passes through a mux into two 2-flop synchronisers, followed by an edge-detect register.
  - A rising edge is a 0->1 transition on the synchronised signal.
  - RO inputs must toggle slower than clk/2; faster input undercounts and is not flagged.
- IDLE:
  - On start=1, latch challenge, set busy=1, go to ARM.
  - start=0 keeps IDLE with outputs held.
- ARM:
  - Lasts exactly 3 cycles to flush the synchronisers after the mux change.
  - Clears both counters.
  - Edges in this state are not counted.
- COUNT:
  - Lasts exactly WIN_CYC cycles, tracked by a window counter of width clog2(WIN_CYC+1).
  - Each detected edge increments the matching counter.
  - Counters saturate at all-ones and never wrap.
- CMP:
  - Lasts 1 cycle.
  - Computes response = (cntA > cntB), unsigned. A tie gives 0; both saturated also gives 0.
  - On the next edge: response register updates, finished=1 for one cycle, busy stays 1 that cycle, then returns to IDLE with busy=0.
- Latency:
  - finished is high in the cycle following edge number WIN_CYC+4, counted from the edge that samples start.
- Ignored inputs:
  - start while busy is ignored; it is not queued.
  - challenge changes during busy are ignored.
- Out-of-range challenge: impossible by width; all codes are valid.

Optional Feature:
- Macro PUF_MAJORITY_EN.
- Defined:
  - The ARM/COUNT/CMP sequence repeats NVOTE times on the latched challenge.
  - Each CMP result increments a vote counter of width clog2(NVOTE+1).
  - Final response = (votes > NVOTE/2).
  - finished fires once, after NVOTE*(WIN_CYC+4) edges.
  - response is not updated between rounds.
- Undefined:
  - Single measurement as above.
  - NVOTE is unused, and the vote logic is absent.

Decomposition:
- Package puf_pkg:
  - state enum {IDLE, ARM, COUNT, CMP}.
  - constant ARM_CYC=3.
  - function clog2.
- One natural sub-module, puf_edge_cnt: synchroniser + edge detect + saturating counter with clear/enable.
  - Instantiated twice (A and B).

Test Plan:
- Reset/idle: rst pulse, no start -> response=0, finished=0, busy=0 indefinitely. Assert rst mid-COUNT -> busy=0 next edge, finished never pulses.
- Basic compare: CHAL_W=3, WIN_CYC=64, challenge=2, ro_in[4] period 4 clk, ro_in[5] period 8 clk.
  - Expect cntA≈16 > cntB≈8, response=1.
  - finished at start-edge+68.
  - Swap the periods -> response=0.
- Tie and saturation: CNT_W=4, both selected ROs period 4 -> both counters saturate at 15, response=0. Identical slow clocks -> tie, response=0.
- Pair isolation: challenge=5; toggle only non-selected inputs ro_in[0..9] and ro_in[12..15] -> counts 0, response=0.
- Start while busy: pulse start at cycles 10 and 40 after the first start -> exactly one finished pulse. A start on the finished cycle is ignored; a start on the next cycle is accepted.
- With PUF_MAJORITY_EN, NVOTE=3: rounds A>B, A<B, A>B, with periods changed between rounds -> response=1, a single finished pulse at 3*68 edges.
